// File: rtl/wave_capture_if.sv
// rtl/wave_capture_if.sv - sample strobe input and capture RAM write port bundle
interface wave_capture_if #(
  parameter int ADDR_W = 8
);
  logic              new_sample_ready;
  logic [15:0]       new_sample_in;
  logic              wave_display_idle;
  logic [ADDR_W:0]   write_address;
  logic              write_enable;
  logic [7:0]        write_sample;
  logic              read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - rising-zero-crossing triggered waveform capture into a double-buffered RAM
module wave_capture #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_COUNT = '1;
  localparam logic [ADDR_W-1:0] ONE_COUNT  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_count_next;
  logic [15:0]       r_prev_sample;
  logic              r_read_index;
  logic              r_write_enable;
  logic [ADDR_W:0]   r_write_address;
  logic [7:0]        r_write_sample;
  logic              w_trigger;
  logic              w_accept;
  logic              w_toggle;

  assign w_trigger = bus.new_sample_ready
                   && ($signed(r_prev_sample) < 16'sd0)
                   && ($signed(bus.new_sample_in) >= 16'sd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_ARMED:  if (w_trigger) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (bus.new_sample_ready && (r_count == LAST_COUNT)) w_state_next = ST_WAIT;
      ST_WAIT:   if (bus.wave_display_idle) w_state_next = ST_ARMED;
      default:   w_state_next = ST_ARMED;
    endcase
  end

  // Count is always zero while armed, so the trigger write lands at the start of the half.
  always_comb begin
    w_accept     = 1'b0;
    w_toggle     = 1'b0;
    w_count_next = r_count;
    unique case (r_state)
      ST_ARMED: begin
        if (w_trigger) begin
          w_accept     = 1'b1;
          w_count_next = ONE_COUNT;
        end
      end
      ST_ACTIVE: begin
        if (bus.new_sample_ready) begin
          w_accept     = 1'b1;
          w_count_next = r_count + ONE_COUNT;
        end
      end
      ST_WAIT: begin
        w_toggle = bus.wave_display_idle;
      end
      default: begin
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count         <= '0;
      r_prev_sample   <= '0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_sample  <= '0;
    end else begin
      r_count        <= w_count_next;
      r_write_enable <= w_accept;
      if (bus.new_sample_ready) begin
        r_prev_sample <= bus.new_sample_in;
      end
      if (w_accept) begin
        r_write_address <= {~r_read_index, r_count};
        r_write_sample  <= {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
      end
      if (w_toggle) begin
        r_read_index <= ~r_read_index;
      end
    end
  end

  assign bus.write_enable  = r_write_enable;
  assign bus.write_address = r_write_address;
  assign bus.write_sample  = r_write_sample;
  assign bus.read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - randomized and directed checks of wave_capture against a capture model
module tb_wave_capture;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_if #(.ADDR_W(ADDR_W)) bus ();

  wave_capture #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0]     m_prev;
  bit              m_capturing;
  bit              m_full;
  bit              m_half;
  int              m_taken;
  bit              exp_we;
  logic [ADDR_W:0] exp_addr;
  logic [7:0]      exp_data;
  int              obs_pulses;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev      = '0;
    m_capturing = 1'b0;
    m_full      = 1'b0;
    m_half      = 1'b0;
    m_taken     = 0;
    exp_we      = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
  endtask

  task automatic emit(input int n, input logic [15:0] smp);
    exp_we   = 1'b1;
    exp_addr = (ADDR_W+1)'((m_half ? 0 : DEPTH) + n);
    exp_data = 8'((int'($signed(smp)) + 32768) >> 8);
  endtask

  // One clock: apply inputs at a falling edge, predict, then inspect at the next falling edge.
  task automatic step(input bit rdy, input logic [15:0] smp, input bit idl);
    bit was_full, was_capt;
    bus.new_sample_ready  = rdy;
    bus.new_sample_in     = smp;
    bus.wave_display_idle = idl;
    was_full = m_full;
    was_capt = m_capturing;
    exp_we   = 1'b0;
    if (rdy) begin
      if (!was_full && !was_capt) begin
        if ($signed(m_prev) < 0 && $signed(smp) >= 0) begin
          emit(0, smp);
          m_capturing = 1'b1;
          m_taken     = 1;
        end
      end else if (was_capt) begin
        emit(m_taken, smp);
        m_taken++;
        if (m_taken == DEPTH) begin
          m_capturing = 1'b0;
          m_full      = 1'b1;
        end
      end
      m_prev = smp;
    end
    if (was_full && idl) begin
      m_full = 1'b0;
      m_half = ~m_half;
    end
    @(negedge clk);
    chk("write_enable",  16'(bus.write_enable),  16'(exp_we));
    chk("write_address", 16'(bus.write_address), 16'(exp_addr));
    chk("write_sample",  16'(bus.write_sample),  16'(exp_data));
    chk("read_index",    16'(bus.read_index),    16'(m_half));
    if (bus.write_enable) obs_pulses++;
  endtask

  task automatic rand_step();
    step($urandom_range(0, 2) != 0, 16'($urandom), bit'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_write_enable",  16'(bus.write_enable),  16'h0);
    chk("rst_write_address", 16'(bus.write_address), 16'h0);
    chk("rst_write_sample",  16'(bus.write_sample),  16'h0);
    chk("rst_read_index",    16'(bus.read_index),    16'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset                 = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    obs_pulses            = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // First strobe after reset cannot trigger, then -5 -> 3 crossing.
    step(1'b1, 16'h0003, 1'b0);
    step(1'b1, 16'hFFFB, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    obs_pulses = 0;
    step(1'b1, 16'h0003, 1'b0);
    chk("first_write_we",   16'(bus.write_enable),  16'h1);
    chk("first_write_addr", 16'(bus.write_address), 16'h100);
    chk("first_write_data", 16'(bus.write_sample),  16'h80);

    for (int i = 0; i < DEPTH - 1; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), bit'($urandom_range(0, 1)));
      step(1'b1, 16'($urandom), 1'b0);
    end
    chk("capture_pulses", 16'(obs_pulses), 16'(DEPTH));
    chk("last_addr", 16'(bus.write_address), 16'h1FF);

    obs_pulses = 0;
    repeat (5) step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    chk("wait_no_writes", 16'(obs_pulses), 16'h0);
    step(1'b0, 16'h0000, 1'b1);
    chk("read_index_toggle", 16'(bus.read_index), 16'h1);

    obs_pulses = 0;
    step(1'b1, 16'h1000, 1'b0);
    step(1'b1, 16'h2000, 1'b0);
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'hF000, 1'b0);
    chk("no_crossing_no_write", 16'(obs_pulses), 16'h0);

    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    chk("zero_trig_addr", 16'(bus.write_address), 16'h000);
    chk("zero_trig_data", 16'(bus.write_sample),  16'h80);
    step(1'b1, 16'h7FFF, 1'b0);
    chk("max_pos_addr", 16'(bus.write_address), 16'h001);
    chk("max_pos_data", 16'(bus.write_sample),  16'hFF);

    for (int i = 0; i < 98; i++) step(1'b1, 16'($urandom), bit'($urandom_range(0, 1)));
    do_reset();

    for (int i = 0; i < 300; i++) rand_step();
    for (int i = 0; i < 3000 && !m_full; i++) rand_step();

    // A crossing that arrives on the re-arm edge must not start a capture.
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0001, 1'b1);
    step(1'b1, 16'h0002, 1'b0);
    chk("rearm_edge_no_trig", 16'(bus.write_enable), 16'h0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    chk("rearm_then_trig", 16'(bus.write_enable), 16'h1);

    for (int i = 0; i < 200; i++) rand_step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter: ADDR_W, default 8, meaning log2 of samples per capture (256 at default).
REQ-002 Port: clk  input  1  system clock; single clock domain.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: new_sample_ready  input  1  one-cycle strobe, high when the player produces a sample (music_player new_sample_generated).
REQ-005 Port: new_sample_in  input  16  signed two's-complement sample (music_player sample_left), valid while new_sample_ready is high.
REQ-006 Port: wave_display_idle  input  1  high when the downstream display is not reading the capture RAM.
REQ-007 Port: write_address  output  ADDR_W+1  capture RAM write address, {~read_index, sample_count}.
REQ-008 Port: write_enable  output  1  one-cycle capture RAM write strobe.
REQ-009 Port: write_sample  output  8  unsigned offset-binary sample to store.
REQ-010 Port: read_index  output  1  selects which RAM half the display reads; the block writes the other half.

Function
REQ-011 FSM states ARMED, ACTIVE, WAIT, with all registers clocked on rising clk.
REQ-012 prev_sample (16-bit register) loads new_sample_in on every new_sample_ready, in every state.
REQ-013 Trigger: new_sample_ready high, prev_sample[15]=1 and new_sample_in[15]=0; value 0 counts as non-negative.
REQ-014 ARMED: on trigger, write the triggering sample at count 0, set count to 1 and go to ACTIVE; otherwise no write and stay.
REQ-015 ACTIVE: each new_sample_ready writes at the current count, then count increments; the write at count 2^ADDR_W-1 moves to WAIT and wraps count to 0.
REQ-016 WAIT: samples are ignored except for the prev_sample update; when wave_display_idle=1, toggle read_index and go to ARMED in the same edge.
REQ-017 Trigger evaluation starts on the first strobe after entering ARMED; a strobe coinciding with the WAIT->ARMED edge is not a trigger.
REQ-018 write_enable is registered: high exactly the cycle after an accepted strobe, for one cycle.
REQ-019 write_address and write_sample are registered together with write_enable and hold their values until the next write.
REQ-020 write_sample = new_sample_in[15:8] with bit 7 inverted (signed to offset-binary; 0x8000->0x00, 0x0000->0x80, 0x7FFF->0xFF).
REQ-021 Back-to-back strobes on consecutive cycles are each accepted; each produces its own write_enable pulse.
REQ-022 Exactly 2^ADDR_W writes per capture, with addresses contiguous within one half; no write ever targets the read_index half.
REQ-023 wave_display_idle is ignored outside WAIT.

Reset
REQ-024 reset low asynchronously forces state=ARMED, count=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-025 Reset asserted mid-capture aborts the capture immediately; no write_enable pulse follows reset release without a fresh trigger.
REQ-026 After reset release, the first strobe cannot trigger, because prev_sample=0 is non-negative.

Verification
REQ-027 Reset pulse -> all outputs 0, state ARMED, read_index 0.
REQ-028 Strobes with samples 0xFFFB (-5) then 0x0003 -> one write_enable the cycle after the second strobe, write_address 9'h100, write_sample 8'h80.
REQ-029 Trigger followed by 255 further strobes -> 256 pulses at addresses 0x100..0x1FF, then no writes; raise wave_display_idle -> read_index=1; next capture writes 0x000..0x0FF.
REQ-030 Strobe sequences 0x1000,0x2000 and 0x8000,0xF000 while ARMED -> no write_enable.
REQ-031 Reset low at count 100 in ACTIVE -> write_enable 0 at once, state ARMED, read_index 0; no writes until a new negative-to-non-negative crossing.
REQ-032 Samples 0x8000, 0x0000, 0x7FFF on consecutive cycles -> trigger on 0x0000; written data 0x80 then 0xFF on consecutive cycles.
